// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants and host transmitter state encoding
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, RELEASE} state_t;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: core-side command handshake of the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error, busy);
  modport slave (input tx_data, tx_valid, output tx_ready, tx_done, tx_error, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes the raw PS/2 lines and flags falling clock edges
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);
  logic [1:0] clk_ff, dat_ff;
  logic       clk_d;
  // two-flop synchronizers plus one delay stage; idle lines reset high so no false edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      clk_ff <= 2'b11;
      dat_ff <= 2'b11;
      clk_d  <= 1'b1;
    end else begin
      clk_ff <= {clk_ff[0], ps2_clk_in};
      dat_ff <= {dat_ff[0], ps2_dat_in};
      clk_d  <= clk_ff[1];
    end
  assign clk_s = clk_ff[1];
  assign dat_s = dat_ff[1];
  assign fall  = clk_d & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over the open-drain PS/2 pair
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 24576000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam int INHIBIT_CYC = (CLK_FREQ_HZ / 1000) * INHIBIT_US / 1000;
  localparam int TIMEOUT_CYC = (CLK_FREQ_HZ / 1000) * TIMEOUT_MS;
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t        state, state_nx;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          drv, clk_s, dat_s, fall, accept, timeout, active;
  ps2_line_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_s      (clk_s),
    .dat_s      (dat_s),
    .fall       (fall)
  );
  assign active  = state != IDLE && state != RELEASE;
  assign accept  = state == IDLE && bus.tx_valid;
  assign timeout = active && to_cnt == TW'(TIMEOUT_CYC - 1);
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next state and result pulses; timeout overrides any state so done/error never coincide
  always_comb begin
    state_nx     = state;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    if (timeout) begin
      state_nx     = RELEASE;
      bus.tx_error = 1'b1;
    end else begin
      case (state)
        IDLE:    if (bus.tx_valid) state_nx = INHIBIT;
        INHIBIT: if (inh_cnt == IW'(INHIBIT_CYC - 1)) state_nx = RTS;
        RTS:     state_nx = DATA;
        DATA:    if (bit_cnt == 4'(FRAME_BITS)) state_nx = ACK;
        ACK:
          if (fall) begin
            state_nx     = RELEASE;
            bus.tx_done  = ~dat_s;
            bus.tx_error = dat_s;
          end
        RELEASE: if (clk_s && dat_s) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end
  // frame shifter, data-line drive and the inhibit/timeout counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      drv     <= 1'b0;
    end else if (accept) begin
      shreg   <= {1'b1, ~^bus.tx_data, bus.tx_data};
      bit_cnt <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == INHIBIT) inh_cnt <= inh_cnt + 1'b1;
      if (active) to_cnt <= to_cnt + 1'b1;
      if (state_nx == RTS) drv <= 1'b1;
      else if (state == DATA && state_nx == DATA && fall && bit_cnt != 4'(FRAME_BITS)) begin
        drv     <= ~shreg[0];
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state_nx != DATA) drv <= 1'b0;
    end
  assign bus.tx_ready = state == IDLE;
  assign bus.busy     = state != IDLE;
  assign ps2_clk_oe   = state == INHIBIT;
  assign ps2_dat_oe   = drv;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors plus corner sequences against a wired-AND device model
module tb_ps2_host_tx;
  localparam int CLK_FREQ_HZ = 2000000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_MS  = 2;
  localparam int INHIBIT_CYC = 200;
  localparam int TIMEOUT_CYC = 4000;
  localparam int HALF        = 80;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe, ps2_clk_line, ps2_dat_line;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, run = 0, last_run = 0, handoffs = 0;
  bit both_seen = 0, handoff_bad = 0, prev_clk_oe = 0;
  ps2_host_tx_if bus ();
  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .INHIBIT_US  (INHIBIT_US),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );
  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);
  always #5 clk = ~clk;
  // pulse counters, inhibit length and clock/data handoff observation
  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_error) err_cnt++;
    if (bus.tx_done && bus.tx_error) both_seen = 1;
    if (prev_clk_oe && !ps2_clk_oe) begin
      handoffs++;
      if (!ps2_dat_oe) handoff_bad = 1;
    end
    if (ps2_clk_oe) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    prev_clk_oe = ps2_clk_oe;
  end
  typedef struct {
    logic [7:0]  data;
    bit          ack_low;
    logic [10:0] exp_bits;
    int          exp_done;
    int          exp_err;
  } vec_t;
  vec_t vecs[3];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("clk_oe_1cyc_after_accept", 32'(ps2_clk_oe), 32'd1);
  endtask
  task automatic wait_rts();
    int n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rts_reached", 32'(n < 1000), 32'd1);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_returns", 32'(bus.tx_ready), 32'd1);
  endtask
  task automatic dev_pulse(output logic s);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    s = ps2_dat_line;
    repeat (HALF) @(negedge clk);
  endtask
  task automatic device_frame(input bit ack_low, output logic [10:0] bits);
    logic s;
    bits = '0;
    wait_rts();
    repeat (20) @(negedge clk);
    bits[0] = ps2_dat_line;
    for (int i = 1; i <= 10; i++) begin
      dev_pulse(s);
      bits[i] = s;
    end
    dev_dat_low = ack_low;
    repeat (10) @(negedge clk);
    dev_pulse(s);
    dev_dat_low = 1'b0;
  endtask
  initial begin
    logic [10:0] bits;
    int d0, e0, n;
    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1, 0};
    vecs[1] = '{8'h07, 1'b1, 11'h40E, 1, 0};
    vecs[2] = '{8'hFF, 1'b0, 11'h7FE, 0, 1};
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.tx_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("reset_done", 32'(bus.tx_done), 32'd0);
    check("reset_error", 32'(bus.tx_error), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vecs[v].data);
      check("busy_in_frame", 32'(bus.busy), 32'd1);
      device_frame(vecs[v].ack_low, bits);
      wait_ready();
      check("line_bits", 32'(bits), 32'(vecs[v].exp_bits));
      check("inhibit_len", 32'(last_run), 32'(INHIBIT_CYC));
      check("done_pulses", 32'(done_cnt - d0), 32'(vecs[v].exp_done));
      check("error_pulses", 32'(err_cnt - e0), 32'(vecs[v].exp_err));
      check("idle_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      repeat (5) @(negedge clk);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55);
    n = 1;
    while (!bus.tx_error && n < TIMEOUT_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT_CYC));
    check("timeout_no_done", 32'(bus.tx_done), 32'd0);
    @(negedge clk);
    check("timeout_oe_off", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    wait_ready();
    check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
    check("timeout_done_none", 32'(done_cnt - d0), 32'd0);
    send(8'hED);
    wait_rts();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) dev_pulse(bits[0]);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    check("bit4_dat_oe_driven", 32'(ps2_dat_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_reset", 32'(bus.tx_ready), 32'd1);
    d0 = done_cnt;
    send(8'hFF);
    device_frame(1'b1, bits);
    wait_ready();
    check("post_reset_bits", 32'(bits), 32'h7FE);
    check("post_reset_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED);
    fork
      device_frame(1'b1, bits);
      begin
        repeat (400) @(negedge clk);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        check("busy_during_retry", 32'(bus.busy), 32'd1);
        repeat (5) @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    wait_ready();
    check("ignored_bits", 32'(bits), 32'h7DA);
    check("ignored_done_once", 32'(done_cnt - d0), 32'd1);
    check("ignored_no_error", 32'(err_cnt - e0), 32'd0);
    repeat (300) @(negedge clk);
    check("no_queued_frame", 32'({bus.tx_ready, ps2_clk_oe}), 32'b10);
    check("done_error_exclusive", 32'(both_seen), 32'd0);
    check("rts_handoff_clean", 32'(handoff_bad), 32'd0);
    check("rts_handoff_count", 32'(handoffs), 32'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
